// File: rtl/onebit_pkg.sv
// Shared constants and types for the 1-bit NAND processor loader.
//   INSTR_BITS : bits per instruction word (bit 0 is the ctrl bit)
//   INSTR_MEM  : maximum words per program
//   PC_W       : processor program-counter width
//   state_e    : loader sequencing states
//   err_e      : sticky error codes reported on the err port
package onebit_pkg;

  localparam int unsigned INSTR_BITS = 13;
  localparam int unsigned INSTR_MEM  = 1000;
  localparam int unsigned PC_W       = 10;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SHIFT,
    RUN,
    ERR
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_UNDERRUN = 2'd1,
    ERR_OVERFLOW = 2'd2
  } err_e;

endpackage

// File: rtl/onebit_load_ctrl_serializer.sv
// instr_serializer: one-word hold register in front of a shift register
// that presents instruction bits LSB first, one bit per cycle.
//   clear         : empty hold, zero shift register and bit counter
//   load          : load din straight into the shift register (first word)
//   bypass        : at word_end, load din straight into the shift register
//   push          : capture din/din_last into the hold register
//   shift_en      : advance one bit (or refill at word_end)
//   bit_out       : bit currently presented to the processor
//   word_end      : current bit is the last bit of the word
//   cur_last      : word in the shift register is the program's last
//   hold_full     : hold register occupied
//   hold_full_nxt : hold occupancy after this cycle (for registered ready)
module instr_serializer #(
  parameter int unsigned W = 13
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic         bypass,
  input  logic         push,
  input  logic         shift_en,
  input  logic [W-1:0] din,
  input  logic         din_last,
  output logic         bit_out,
  output logic         word_end,
  output logic         cur_last,
  output logic         hold_full,
  output logic         hold_full_nxt
);

  localparam int unsigned CNT_W = $clog2(W);

  logic [W-1:0]     sr_q, sr_d, hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d, hold_last_q, hold_last_d;
  logic             hold_full_q, hold_full_d;

  assign word_end      = (cnt_q == CNT_W'(W - 1));
  assign bit_out       = sr_q[0];
  assign cur_last      = last_q;
  assign hold_full     = hold_full_q;
  assign hold_full_nxt = hold_full_d;

  always_comb begin
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    hold_d      = hold_q;
    hold_last_d = hold_last_q;
    hold_full_d = hold_full_q;
    if (clear) begin
      sr_d        = '0;
      cnt_d       = '0;
      last_d      = 1'b0;
      hold_d      = '0;
      hold_last_d = 1'b0;
      hold_full_d = 1'b0;
    end else if (load) begin
      sr_d   = din;
      last_d = din_last;
      cnt_d  = '0;
    end else if (shift_en) begin
      if (!word_end) begin
        sr_d  = sr_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (push) begin
          hold_d      = din;
          hold_last_d = din_last;
          hold_full_d = 1'b1;
        end
      end else if (bypass) begin
        sr_d   = din;
        last_d = din_last;
        cnt_d  = '0;
      end else if (hold_full_q) begin
        sr_d        = hold_q;
        last_d      = hold_last_q;
        cnt_d       = '0;
        hold_full_d = 1'b0;
      end else begin
        // Nothing to follow: the final shift drains the register to zero
        // so bit_out idles low once loading stops.
        sr_d   = sr_q >> 1;
        last_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q        <= '0;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      hold_q      <= '0;
      hold_last_q <= 1'b0;
      hold_full_q <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
      hold_last_q <= hold_last_d;
      hold_full_q <= hold_full_d;
    end
  end

endmodule

// File: rtl/onebit_load_ctrl.sv
// onebit_load_ctrl: program loader and run sequencer for the 1-bit NAND
// processor. Accepts instruction words on a valid/ready stream, holds the
// processor in reset, streams the words gap-free into its bit-serial load
// port (proc_en + proc_in0, LSB first), then releases it into run mode.
//   start/stop            : begin load (IDLE/ERR only) / abort to IDLE
//   word_valid/data/last  : instruction stream, word_ready back-pressure
//   proc_reset/en/in0     : processor reset, load enable, load data bit
//   busy/running/done     : ARM|SHIFT, RUN, one-cycle RUN_LIMIT expiry
//   err                   : 0 none, 1 underrun, 2 overflow (sticky)
//   words_loaded          : words fully shifted in
//   run_cycles            : cycles spent in RUN, saturating
module onebit_load_ctrl
  import onebit_pkg::*;
#(
  parameter int unsigned INSTR_BITS = onebit_pkg::INSTR_BITS,
  parameter int unsigned INSTR_MEM  = onebit_pkg::INSTR_MEM,
  parameter int unsigned RUN_LIMIT  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  word_valid,
  input  logic [INSTR_BITS-1:0] word_data,
  input  logic                  word_last,
  output logic                  word_ready,
  output logic                  proc_reset,
  output logic                  proc_en,
  output logic                  proc_in0,
  output logic                  busy,
  output logic                  running,
  output logic                  done,
  output logic [1:0]            err,
  output logic [PC_W-1:0]       words_loaded,
  output logic [15:0]           run_cycles
);

  localparam int unsigned     ACC_W   = PC_W + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(INSTR_MEM);
  localparam logic [PC_W-1:0]  WL_MAX  = PC_W'(INSTR_MEM - 1);

  state_e          state_q, state_d;
  logic [1:0]      err_q, err_d;
  logic [PC_W-1:0] wl_q, wl_d;
  logic [15:0]     rc_q, rc_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic            last_acc_q, last_acc_d;
  logic            ready_q, ready_d, done_q, done_d;
  logic            proc_reset_q, proc_reset_d, proc_en_q, proc_en_d;
  logic            busy_q, busy_d, running_q, running_d;
  logic            hs, clear, load, bypass, push, shift_en;
  logic            word_end, cur_last, hold_full, hold_full_nxt;

  assign hs = word_valid && ready_q;

  instr_serializer #(.W(INSTR_BITS)) u_ser (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .load         (load),
    .bypass       (bypass),
    .push         (push),
    .shift_en     (shift_en),
    .din          (word_data),
    .din_last     (word_last),
    .bit_out      (proc_in0),
    .word_end     (word_end),
    .cur_last     (cur_last),
    .hold_full    (hold_full),
    .hold_full_nxt(hold_full_nxt)
  );

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    wl_d       = wl_q;
    rc_d       = rc_q;
    acc_d      = acc_q;
    last_acc_d = last_acc_q;
    done_d     = 1'b0;
    clear      = 1'b0;
    load       = 1'b0;
    bypass     = 1'b0;
    push       = 1'b0;
    shift_en   = 1'b0;
    if (stop) begin
      state_d = IDLE;
      clear   = 1'b1;
    end else begin
      case (state_q)
        IDLE, ERR: if (start) begin
          state_d    = ARM;
          err_d      = ERR_NONE;
          wl_d       = '0;
          rc_d       = '0;
          acc_d      = '0;
          last_acc_d = 1'b0;
          clear      = 1'b1;
        end
        ARM: if (hs) begin
          load       = 1'b1;
          acc_d      = acc_q + 1'b1;
          last_acc_d = word_last;
          state_d    = SHIFT;
        end
        SHIFT: begin
          shift_en = 1'b1;
          if (hs) begin
            acc_d      = acc_q + 1'b1;
            last_acc_d = word_last;
            if (word_end) bypass = 1'b1;
            else          push   = 1'b1;
          end
          if (word_end) begin
            wl_d = wl_q + 1'b1;
            if (cur_last) begin
              state_d = RUN;
            end else if (wl_q == WL_MAX) begin
              state_d = ERR;
              err_d   = ERR_OVERFLOW;
            end else if (!(hold_full || hs)) begin
              state_d = ERR;
              err_d   = ERR_UNDERRUN;
            end
          end
        end
        RUN: begin
          if (rc_q != '1) rc_d = rc_q + 1'b1;
          if ((RUN_LIMIT != 0) && ({16'd0, rc_q} == RUN_LIMIT - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // Outputs are registered, so they are derived from the next state.
    ready_d      = ((state_d == ARM) || (state_d == SHIFT)) && !hold_full_nxt &&
                   !last_acc_d && (acc_d < ACC_MAX);
    proc_reset_d = (state_d == IDLE) || (state_d == ARM) || (state_d == ERR);
    proc_en_d    = (state_d == SHIFT);
    busy_d       = (state_d == ARM) || (state_d == SHIFT);
    running_d    = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      err_q        <= ERR_NONE;
      wl_q         <= '0;
      rc_q         <= '0;
      acc_q        <= '0;
      last_acc_q   <= 1'b0;
      ready_q      <= 1'b0;
      done_q       <= 1'b0;
      proc_reset_q <= 1'b1;
      proc_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      err_q        <= err_d;
      wl_q         <= wl_d;
      rc_q         <= rc_d;
      acc_q        <= acc_d;
      last_acc_q   <= last_acc_d;
      ready_q      <= ready_d;
      done_q       <= done_d;
      proc_reset_q <= proc_reset_d;
      proc_en_q    <= proc_en_d;
      busy_q       <= busy_d;
      running_q    <= running_d;
    end
  end

  assign word_ready   = ready_q;
  assign done         = done_q;
  assign proc_reset   = proc_reset_q;
  assign proc_en      = proc_en_q;
  assign busy         = busy_q;
  assign running      = running_q;
  assign err          = err_q;
  assign words_loaded = wl_q;
  assign run_cycles   = rc_q;

endmodule

// File: tb/tb_onebit_load_ctrl.sv
// Bench for onebit_load_ctrl (INSTR_MEM=4, RUN_LIMIT=10). Programs are
// streamed by a host that offers word 1 only d1 cycles after the first
// handshake; the expected outcome (words streamed, error code) and the
// expected bit stream come from the loader's timing rules in plain
// arithmetic: word k+1 must arrive by the last bit of word k.
module tb_onebit_load_ctrl;

  localparam int MEM   = 4;
  localparam int LIMIT = 10;

  logic        clk = 1'b0;
  logic        reset, start, stop, word_valid, word_last;
  logic [12:0] word_data;
  logic        word_ready, proc_reset, proc_en, proc_in0;
  logic        busy, running, done;
  logic [1:0]  err;
  logic [9:0]  words_loaded;
  logic [15:0] run_cycles;

  int passes = 0, fails = 0, total = 0;
  logic [12:0] prog [4];
  bit ok;

  always #5 clk = ~clk;

  onebit_load_ctrl #(.INSTR_BITS(13), .INSTR_MEM(MEM), .RUN_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .word_valid(word_valid), .word_data(word_data), .word_last(word_last),
    .word_ready(word_ready), .proc_reset(proc_reset), .proc_en(proc_en),
    .proc_in0(proc_in0), .busy(busy), .running(running), .done(done),
    .err(err), .words_loaded(words_loaded), .run_cycles(run_cycles)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_proc_reset"}, proc_reset, 1);
    chk({tag, "_proc_en"}, proc_en, 0);
    chk({tag, "_proc_in0"}, proc_in0, 0);
    chk({tag, "_ready"}, word_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_running"}, running, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_wl"}, words_loaded, 0);
    chk({tag, "_rc"}, run_cycles, 0);
  endtask

  // Load prog[0..n-1]; word 1 is offered from d1 cycles after the first
  // handshake, every other word as early as possible.
  task automatic do_program(input int n, input bit mark_last, input int d1, output bit success);
    int idx = 0, h = -1, first_en = -1, en_len = 0, nb = 0, en_bad = 0;
    int streamed, exp_err;
    bit ended = 0, seen_en = 0, pend = 0, hs;
    logic [63:0] cap = '0, expv = '0;
    if (n >= 2 && d1 > 13) begin
      streamed = 1; exp_err = 1;
    end else if (!mark_last) begin
      streamed = n; exp_err = (n == MEM) ? 2 : 1;
    end else begin
      streamed = n; exp_err = 0;
    end
    for (int k = 0; k < streamed; k++)
      for (int j = 0; j < 13; j++) expv[13*k+j] = prog[k][j];
    success = (exp_err == 0);

    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    chk("arm_ready", word_ready, 1);
    chk("arm_busy", busy, 1);
    chk("arm_proc_reset", proc_reset, 1);
    chk("arm_err", err, 0);
    chk("arm_wl", words_loaded, 0);

    for (int c = 0; c < 13*n + 40; c++) begin
      if (pend) begin
        chk("ready_after_final", word_ready, 0);
        pend = 0;
      end
      if (proc_en) begin
        if (!seen_en) first_en = c;
        seen_en = 1;
        en_len++;
        if (proc_reset || !busy) en_bad++;
        if (nb < 64) cap[nb] = proc_in0;
        nb++;
      end else if (seen_en) begin
        ended = 1;
      end
      if (ended) break;
      word_valid = (idx < n) && (idx != 1 || (h >= 0 && c - h >= d1));
      word_data  = prog[(idx < n) ? idx : 0];
      word_last  = mark_last && (idx == n - 1);
      hs = word_valid && word_ready;
      @(posedge clk); #1;
      if (hs) begin
        if (idx == 0) h = c;
        idx++;
        if (idx == n) pend = 1;
      end
    end
    word_valid = 1'b0;
    word_last  = 1'b0;

    chk("load_end_seen", ended, 1);
    chk("en_latency", first_en - h, 1);
    chk("en_len", en_len, 13*streamed);
    chk("en_ctrl", en_bad, 0);
    chk("bits", cap, expv);
    chk("err", err, exp_err);
    chk("words_loaded", words_loaded, streamed);
    chk("running", running, (exp_err == 0));
    chk("proc_reset_after", proc_reset, (exp_err != 0));
  endtask

  // Entered on the first RUN cycle; RUN must last exactly LIMIT cycles.
  task automatic check_run();
    int rc = 0;
    bit fin = 0;
    for (int c = 0; c < LIMIT + 20; c++) begin
      if (!running) begin
        fin = 1;
        break;
      end
      rc++;
      @(posedge clk); #1;
    end
    chk("run_end_seen", fin, 1);
    chk("run_len", rc, LIMIT);
    chk("done_pulse", done, 1);
    chk("run_cycles", run_cycles, LIMIT);
    chk("run_end_proc_reset", proc_reset, 1);
    chk("run_end_busy", busy, 0);
    @(posedge clk); #1;
    chk("done_once", done, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    word_valid = 1'b0; word_data = '0; word_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_ready", word_ready, 0);

    // Normal three-word load, then the RUN_LIMIT expiry.
    prog[0] = 13'h1ABC; prog[1] = 13'h0F0F; prog[2] = 13'h1555; prog[3] = 13'h0000;
    do_program(3, 1'b1, 1, ok);
    if (ok) check_run();

    // Underrun: word 1 withheld 20 cycles; next start clears err.
    for (int i = 0; i < 4; i++) prog[i] = 13'($urandom);
    do_program(2, 1'b1, 20, ok);

    // Bypass: word 1 offered exactly on bit 12 of word 0.
    for (int i = 0; i < 4; i++) prog[i] = 13'($urandom);
    do_program(2, 1'b1, 13, ok);
    if (ok) check_run();

    // Overflow: INSTR_MEM words, none marked last.
    for (int i = 0; i < 4; i++) prog[i] = 13'($urandom);
    do_program(4, 1'b0, 1, ok);

    // Random programs and word-1 arrival times.
    for (int t = 0; t < 8; t++) begin
      int n, d1;
      n  = $urandom_range(4, 1);
      d1 = (n >= 2) ? $urandom_range(20, 1) : 1;
      for (int i = 0; i < 4; i++) prog[i] = 13'($urandom);
      do_program(n, 1'b1, d1, ok);
      if (ok) check_run();
    end

    // stop in the middle of SHIFT.
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    word_valid = 1'b1; word_data = 13'h1FFF; word_last = 1'b0;
    @(posedge clk); #1;
    word_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("stop_pre_en", proc_en, 1);
    chk("stop_pre_in0", proc_in0, 1);
    stop = 1'b1; @(posedge clk); #1; stop = 1'b0;
    chk("stop_proc_en", proc_en, 0);
    chk("stop_proc_reset", proc_reset, 1);
    chk("stop_proc_in0", proc_in0, 0);
    chk("stop_busy", busy, 0);
    chk("stop_ready", word_ready, 0);

    // reset asserted during RUN.
    for (int i = 0; i < 4; i++) prog[i] = 13'($urandom);
    do_program(2, 1'b1, 1, ok);
    @(posedge clk); #1;
    chk("rst_pre_running", running, 1);
    reset = 1'b1; @(posedge clk); #1;
    check_reset_vals("rst_run");
    reset = 1'b0;

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
